// File: rtl/line_packetizer.sv
// Frames each CCD scan line into a byte packet (header, big-endian pixels, trailer)
// for the USB TX FIFO, buffering pixels because the pixel source cannot be stalled.
module line_packetizer #(
    parameter int          PIX_PER_LINE = 3648,
    parameter int          FIFO_AW      = 8,
    parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        line_sync,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        tx_full,
    output logic        tx_wrreq,
    output logic [7:0]  tx_data,
    output logic [15:0] line_cnt,
    output logic [15:0] missed_lines,
    output logic        overflow,
    output logic        busy
);

    localparam int          DEPTH    = 2 ** FIFO_AW;
    localparam logic [15:0] PPL      = 16'(PIX_PER_LINE);
    localparam logic [15:0] PPL_LAST = 16'(PIX_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PIX_HI,
        S_PIX_LO,
        S_TRL
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [15:0]        k, k_nxt;
    logic [15:0]        cur_word, cur_word_nxt;
    logic               cur_from_fifo, cur_from_fifo_nxt;
    logic [15:0]        checksum, cksum_nxt;
    logic [1:0]         flags;
    logic [15:0]        pkt_line;
    logic               capture_active;
    logic [15:0]        cap_n;
    logic               emit, done, pop;
    logic [7:0]         emit_byte;

    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_empty, fifo_full;
    logic [15:0]        fifo_head;

    logic               accept, pix_take, fifo_wr;

    assign busy       = capture_active || (state != S_IDLE);
    assign accept     = line_sync && en && !busy;
    assign pix_take   = capture_active && en && pix_valid;
    assign fifo_empty = (count == '0);
    // Occupancy is one bit wider than the pointers, so its MSB alone marks full.
    assign fifo_full  = count[FIFO_AW];
    assign fifo_wr    = pix_take && !fifo_full;
    assign fifo_head  = mem[rd_ptr];

    // NOTE: pixel storage has no reset; occupancy and pointers define what is valid,
    // and leaving the array unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= pix_data;
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred;
    // blocking assignments are correct in combinational logic.
    always_comb begin
        state_nxt         = state;
        idx_nxt           = idx;
        k_nxt             = k;
        cur_word_nxt      = cur_word;
        cur_from_fifo_nxt = cur_from_fifo;
        cksum_nxt         = checksum;
        emit              = 1'b0;
        emit_byte         = 8'h00;
        pop               = 1'b0;
        done              = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_HDR;
                    idx_nxt   = '0;
                end
            end
            S_HDR: begin
                if (!tx_full) begin
                    emit = 1'b1;
                    case (idx)
                        3'd0:    emit_byte = SYNC_WORD[15:8];
                        3'd1:    emit_byte = SYNC_WORD[7:0];
                        3'd2:    emit_byte = pkt_line[15:8];
                        3'd3:    emit_byte = pkt_line[7:0];
                        3'd4:    emit_byte = PPL[15:8];
                        default: emit_byte = PPL[7:0];
                    endcase
                    if (idx == 3'd5) begin
                        state_nxt = S_PIX_HI;
                        idx_nxt   = '0;
                        k_nxt     = '0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            S_PIX_HI: begin
                // Pad with zeros only once capture can no longer supply the word.
                if (!tx_full && (!fifo_empty || !capture_active)) begin
                    cur_word_nxt      = fifo_empty ? 16'h0000 : fifo_head;
                    cur_from_fifo_nxt = !fifo_empty;
                    emit              = 1'b1;
                    emit_byte         = cur_word_nxt[15:8];
                    state_nxt         = S_PIX_LO;
                end
            end
            S_PIX_LO: begin
                if (!tx_full) begin
                    emit      = 1'b1;
                    emit_byte = cur_word[7:0];
                    pop       = cur_from_fifo;
                    cksum_nxt = checksum + cur_word;
                    if (k == PPL_LAST) begin
                        state_nxt = S_TRL;
                        idx_nxt   = '0;
                    end else begin
                        k_nxt     = k + 16'd1;
                        state_nxt = S_PIX_HI;
                    end
                end
            end
            S_TRL: begin
                if (!tx_full) begin
                    emit = 1'b1;
                    case (idx)
                        3'd0:    emit_byte = {6'b0, flags};
                        3'd1:    emit_byte = checksum[15:8];
                        default: emit_byte = checksum[7:0];
                    endcase
                    if (idx == 3'd2) begin
                        state_nxt = S_IDLE;
                        done      = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            k              <= '0;
            cur_word       <= '0;
            cur_from_fifo  <= 1'b0;
            checksum       <= '0;
            flags          <= '0;
            pkt_line       <= '0;
            capture_active <= 1'b0;
            cap_n          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            line_cnt       <= '0;
            missed_lines   <= '0;
            overflow       <= 1'b0;
            tx_wrreq       <= 1'b0;
            tx_data        <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            k             <= k_nxt;
            cur_word      <= cur_word_nxt;
            cur_from_fifo <= cur_from_fifo_nxt;
            checksum      <= accept ? 16'h0000 : cksum_nxt;
            tx_wrreq      <= emit;
            if (emit) tx_data <= emit_byte;
            if (done) line_cnt <= line_cnt + 16'd1;
            if (line_sync && en && busy && missed_lines != 16'hFFFF)
                missed_lines <= missed_lines + 16'd1;

            if (accept) begin
                capture_active <= 1'b1;
                cap_n          <= '0;
                flags          <= '0;
                pkt_line       <= line_cnt;
            end else if (capture_active && !en) begin
                capture_active <= 1'b0;
                flags[1]       <= 1'b1;
            end else if (pix_take) begin
                cap_n <= cap_n + 16'd1;
                if (cap_n == PPL_LAST) capture_active <= 1'b0;
                if (fifo_full) begin
                    overflow <= 1'b1;
                    flags[0] <= 1'b1;
                end
            end

            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_line_packetizer.sv
// Directed bench for line_packetizer: expected packet bytes are queued when a line is
// driven and compared as the DUT writes them; dut_a (4 px, deep FIFO), dut_b (8 px, 4-word FIFO).
module tb_line_packetizer;

    localparam logic [15:0] SYNC = 16'hA55A;

    logic        clk = 1'b0;
    logic        rst, en, line_sync, pix_valid, tx_full;
    logic [15:0] pix_data;

    logic        tx_wrreq_a, tx_wrreq_b, overflow_a, overflow_b, busy_a, busy_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic [15:0] line_cnt_a, line_cnt_b, missed_a, missed_b;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [15:0] wq[$];
    bit          chk_a = 1'b0;
    bit          chk_b = 1'b0;
    logic        full_prev = 1'b0;

    always #5 clk = ~clk;

    line_packetizer #(.PIX_PER_LINE(4), .FIFO_AW(8), .SYNC_WORD(SYNC)) dut_a (
        .clk(clk), .rst(rst), .en(en), .line_sync(line_sync),
        .pix_valid(pix_valid), .pix_data(pix_data), .tx_full(tx_full),
        .tx_wrreq(tx_wrreq_a), .tx_data(tx_data_a), .line_cnt(line_cnt_a),
        .missed_lines(missed_a), .overflow(overflow_a), .busy(busy_a)
    );

    line_packetizer #(.PIX_PER_LINE(8), .FIFO_AW(2), .SYNC_WORD(SYNC)) dut_b (
        .clk(clk), .rst(rst), .en(en), .line_sync(line_sync),
        .pix_valid(pix_valid), .pix_data(pix_data), .tx_full(tx_full),
        .tx_wrreq(tx_wrreq_b), .tx_data(tx_data_b), .line_cnt(line_cnt_b),
        .missed_lines(missed_b), .overflow(overflow_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [15:0] d);
        pix_valid = 1'b1;
        pix_data  = d;
        step();
        pix_valid = 1'b0;
    endtask

    // Builds the full expected packet from wq (zero-padded to ppl words).
    task automatic push_exp(input bit to_b, input logic [15:0] line, input int ppl,
                            input logic [1:0] flg);
        logic [15:0] sum = 16'h0000;
        logic [15:0] w;
        logic [15:0] p = 16'(ppl);
        logic [7:0]  b[$];
        b = {SYNC[15:8], SYNC[7:0], line[15:8], line[7:0], p[15:8], p[7:0]};
        for (int i = 0; i < ppl; i++) begin
            w = (i < wq.size()) ? wq[i] : 16'h0000;
            b.push_back(w[15:8]);
            b.push_back(w[7:0]);
            sum = sum + w;
        end
        b.push_back({6'b0, flg});
        b.push_back(sum[15:8]);
        b.push_back(sum[7:0]);
        foreach (b[i]) begin
            if (to_b) exp_b.push_back(b[i]);
            else      exp_a.push_back(b[i]);
        end
    endtask

    task automatic drain(input bit to_b);
        int n = 0;
        while ((to_b ? exp_b.size() : exp_a.size()) != 0 && n < 400) begin
            step();
            n++;
        end
        check(to_b ? "b_drain" : "a_drain", to_b ? exp_b.size() : exp_a.size(), 0);
    endtask

    always @(posedge clk) full_prev <= tx_full;

    always @(negedge clk) begin
        if (tx_wrreq_a) begin
            check("a_wr_while_full", full_prev, 0);
            if (chk_a) begin
                check("a_byte_expected", 32'(exp_a.size() != 0), 1);
                if (exp_a.size() != 0) check("a_byte", tx_data_a, exp_a.pop_front());
            end
        end
        if (tx_wrreq_b) begin
            check("b_wr_while_full", full_prev, 0);
            if (chk_b) begin
                check("b_byte_expected", 32'(exp_b.size() != 0), 1);
                if (exp_b.size() != 0) check("b_byte", tx_data_b, exp_b.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; line_sync = 1'b0; pix_valid = 1'b0;
        pix_data = 16'h0000; tx_full = 1'b0;
        step(); step();
        check("rst_wrreq", tx_wrreq_a, 0);
        check("rst_data", tx_data_a, 0);
        check("rst_line_cnt", line_cnt_a, 0);
        check("rst_missed", missed_a, 0);
        check("rst_overflow", overflow_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        step();

        // Basic packet, no back-pressure.
        chk_a = 1'b1;
        wq = {16'd1, 16'd2, 16'd3, 16'd4};
        push_exp(1'b0, 16'h0000, 4, 2'b00);
        line_sync = 1'b1; step(); line_sync = 1'b0;
        pix(16'd1); pix(16'd2); pix(16'd3); pix(16'd4);
        drain(1'b0);
        check("t1_line_cnt", line_cnt_a, 1);
        check("t1_busy", busy_a, 0);

        // Same packet with tx_full held for 5 edges at the third header byte.
        push_exp(1'b0, 16'h0001, 4, 2'b00);
        line_sync = 1'b1; step(); line_sync = 1'b0;
        pix_valid = 1'b1;
        pix_data = 16'd1; step();
        pix_data = 16'd2; step();
        pix_data = 16'd3; tx_full = 1'b1; step();
        pix_data = 16'd4; step();
        pix_valid = 1'b0;
        step(); step(); step();
        tx_full = 1'b0;
        drain(1'b0);
        check("t2_line_cnt", line_cnt_a, 2);
        check("t2_overflow", overflow_a, 0);

        // Short line: two pixels then en low, remaining words padded.
        wq = {16'd7, 16'd9};
        push_exp(1'b0, 16'h0002, 4, 2'b10);
        line_sync = 1'b1; step(); line_sync = 1'b0;
        pix(16'd7); pix(16'd9);
        en = 1'b0; step();
        drain(1'b0);
        en = 1'b1;
        check("t3_line_cnt", line_cnt_a, 3);
        check("t3_missed", missed_a, 0);

        // Reset while the FSM sits in PIX_LO.
        chk_a = 1'b0;
        exp_a.delete();
        line_sync = 1'b1; step(); line_sync = 1'b0;
        pix(16'd1); pix(16'd2); pix(16'd3); pix(16'd4);
        step(); step(); step();
        check("t5_pre_busy", busy_a, 1);
        check("t5_pre_wrreq", tx_wrreq_a, 1);
        check("t5_pre_line_cnt", line_cnt_a, 3);
        rst = 1'b1; step();
        check("t5_wrreq", tx_wrreq_a, 0);
        check("t5_line_cnt", line_cnt_a, 0);
        check("t5_missed", missed_a, 0);
        check("t5_busy", busy_a, 0);
        rst = 1'b0; step();

        // Clean packet after reset, with two line_sync pulses while busy.
        chk_a = 1'b1;
        wq = {16'd1, 16'd2, 16'd3, 16'd4};
        push_exp(1'b0, 16'h0000, 4, 2'b00);
        line_sync = 1'b1; step(); line_sync = 1'b0;
        pix(16'd1);
        line_sync = 1'b1; pix(16'd2); line_sync = 1'b0;
        pix(16'd3);
        line_sync = 1'b1; pix(16'd4); line_sync = 1'b0;
        drain(1'b0);
        check("t6_missed", missed_a, 2);
        check("t6_line_cnt", line_cnt_a, 1);
        repeat (10) step();
        check("t6_idle_busy", busy_a, 0);
        wq = {16'h1234, 16'hFFFF, 16'h8000, 16'h0001};
        push_exp(1'b0, 16'h0001, 4, 2'b00);
        line_sync = 1'b1; step(); line_sync = 1'b0;
        pix(16'h1234); pix(16'hFFFF); pix(16'h8000); pix(16'h0001);
        drain(1'b0);
        check("t6b_line_cnt", line_cnt_a, 2);
        check("t6b_missed", missed_a, 2);

        // FIFO overflow on the 4-word instance while the TX FIFO is full.
        chk_a = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        chk_b = 1'b1;
        check("t4_overflow_pre", overflow_b, 0);
        wq = {16'h0101, 16'h0101, 16'h0101, 16'h0101};
        push_exp(1'b1, 16'h0000, 8, 2'b01);
        tx_full = 1'b1;
        line_sync = 1'b1; step(); line_sync = 1'b0;
        for (int i = 0; i < 8; i++) pix(16'h0101);
        check("t4_overflow", overflow_b, 1);
        check("t4_busy", busy_b, 1);
        check("t4_overflow_a", overflow_a, 0);
        tx_full = 1'b0;
        drain(1'b1);
        check("t4_line_cnt", line_cnt_b, 1);
        step();
        check("t4_busy_end", busy_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_packetizer.md
Name: line_packetizer

Overview:
- Sits between the CCD pixel stream (16-bit pixel words with a valid strobe) and the byte-wide USB TX FIFO write port.
- Frames each scan line as a packet so host software can resynchronise and detect loss: sync/header, big-endian pixel bytes, then a trailer with flags and checksum.
- Buffers pixels internally because the pixel source cannot be stalled while the TX FIFO may back-pressure.

Parameters:
- PIX_PER_LINE, 3648, pixels per packet (1..65535).
- FIFO_AW, 8, pixel FIFO address width (depth 2**FIFO_AW words).
- SYNC_WORD, 16'hA55A, packet sync pattern.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; low ends any capture in progress.
- line_sync  in  1  one-cycle pulse, start of a new CCD line.
- pix_valid  in  1  pix_data valid this cycle.
- pix_data  in  16  pixel sample.
- tx_full  in  1  TX FIFO full; no write permitted while high.
- tx_wrreq  out  1  write strobe, one byte per asserted cycle.
- tx_data  out  8  byte to write, valid when tx_wrreq=1.
- line_cnt  out  16  number of packets completed (trailer sent).
- missed_lines  out  16  line_sync pulses ignored because the block was busy.
- overflow  out  1  sticky; a pixel was dropped on FIFO full.
- busy  out  1  capture active or output FSM not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at an edge:
  - tx_wrreq=0, tx_data=0, line_cnt=0, missed_lines=0, overflow=0, busy=0.
  - FIFO emptied, capture and output FSM to IDLE, checksum and flags cleared.
  - Reset mid-packet abandons the packet with no trailer.
- Line acceptance:
  - line_sync with en=1 and busy=0 is accepted.
  - On acceptance: capture_active=1, pixel counter cap_n=0, checksum=0, flags=0, pkt_line=line_cnt, output FSM IDLE->HDR.
  - line_sync with busy=1 is ignored and missed_lines increments, saturating at 16'hFFFF.
  - line_sync with en=0 is ignored and not counted.
- Capture:
  - While capture_active, each pix_valid writes pix_data to the FIFO and increments cap_n.
  - At cap_n=PIX_PER_LINE, capture_active clears and further pixels are discarded silently.
  - pix_valid while FIFO full: word dropped, cap_n still increments, overflow=1 (sticky), flags[0]=1.
  - en falling while capture_active: capture ends and flags[1]=1 (short line).
- Output FSM: IDLE, HDR, PIX_HI, PIX_LO, TRL.
  - A byte is emitted only when tx_full=0. The FSM holds state and byte index otherwise.
  - tx_wrreq is registered. First header byte appears at the earliest on the cycle after the accepting edge.
  - HDR, 6 bytes in order: SYNC_WORD[15:8], SYNC_WORD[7:0], pkt_line[15:8], pkt_line[7:0], PIX_PER_LINE[15:8], PIX_PER_LINE[7:0].
  - PIX_HI/PIX_LO: output pixel index k runs 0..PIX_PER_LINE-1.
    - Source word: FIFO head if the FIFO is non-empty; otherwise 16'h0000 pad if capture has ended (short line or dropped pixels); otherwise wait with tx_wrreq=0.
    - Emit word[15:8] then word[7:0]. Pop the FIFO on the LO byte.
    - checksum += word, mod 2^16, pads included.
  - TRL, 3 bytes: {6'b0, flags[1:0]}, checksum[15:8], checksum[7:0].
  - After the last trailer byte: line_cnt increments (wraps 16'hFFFF->0), FSM->IDLE.
- Packet length: always 6 + 2*PIX_PER_LINE + 3 bytes.
- Simultaneous events:
  - FIFO write and pop in the same cycle are both honoured; occupancy is unchanged.
  - line_sync on the same edge the FSM returns to IDLE is ignored (busy still 1) and counted as missed.
- Width rules: cap_n and k are 16-bit. FIFO occupancy is FIFO_AW+1 bits.

Test Plan:
- PIX_PER_LINE=4, tx_full=0, line_sync then pixels 1,2,3,4 one per cycle -> bytes A5 5A 00 00 00 04 00 01 00 02 00 03 00 04 00 00 0A; line_cnt=1.
- Same packet with tx_full high for 5 cycles at the 3rd header byte -> no tx_wrreq while full; identical byte sequence; no pixel loss.
- PIX_PER_LINE=4, only pixels 7,9 then en=0 -> pixel bytes 00 07 00 09 00 00 00 00, trailer 02 00 10.
- FIFO_AW=2, PIX_PER_LINE=8, tx_full held high, 8 pixels of 16'h0101 -> overflow=1; on release, 4 real words + 4 pads; trailer flags=01, checksum 0404.
- line_sync pulsed twice during a packet -> missed_lines=2; second packet header carries line 0001 only after the next accepted line_sync.
- rst asserted mid-PIX_LO -> tx_wrreq=0 next cycle, all counters 0; next line_sync yields a clean packet with line 0000.
